// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler: FSM states,
// UART register offsets, control/status bit positions and byte-enable patterns.
package uart_sched_pkg;

   typedef enum logic [2:0] {CFG, ARB, POLL, PWAIT, WRITE} schedState_t;

   localparam int REG_CTRL = 0;
   localparam int REG_DATA = 1;

   localparam int TXEN    = 16;
   localparam int RXEN    = 17;
   localparam int TX_FULL = 19;
   localparam int FC_EN   = 21;

   localparam logic [3:0] BE_CFG  = 4'b0111;
   localparam logic [3:0] BE_POLL = 4'b1111;
   localparam logic [3:0] BE_DATA = 4'b0001;

   // Control word: baud divisor in the low half, transmitter always enabled.
   function automatic logic [31:0] cfgWord(input logic [15:0] clksPerBit,
                                           input logic rxEn,
                                           input logic fcEn);
      logic [31:0] word;
      word        = {16'h0, clksPerBit};
      word[TXEN]  = 1'b1;
      word[RXEN]  = rxEn;
      word[FC_EN] = fcEn;
      return word;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle of the Avalon master bus and the requester byte streams around the scheduler.
// Member names keep their direction as seen from the scheduler (master side).
interface uart_tx_scheduler_if #(
   parameter int P_NUM_REQ = 4,
   parameter int P_ADDR_W  = 30
);
   logic [P_ADDR_W-1:0]    o_AV_Address;
   logic [3:0]             o_AV_ByteEn;
   logic                   o_AV_Read;
   logic                   o_AV_Write;
   logic [31:0]            o_AV_WriteData;
   logic [31:0]            i_AV_ReadData;
   logic                   i_AV_WaitRequest;

   logic [P_NUM_REQ-1:0]   i_Req_Valid;
   logic [8*P_NUM_REQ-1:0] i_Req_Data;
   logic [P_NUM_REQ-1:0]   i_Req_Last;
   logic [P_NUM_REQ-1:0]   o_Req_Ready;
   logic [P_NUM_REQ-1:0]   o_Grant;
   logic                   o_CfgDone;

   modport master (
      output o_AV_Address, o_AV_ByteEn, o_AV_Read, o_AV_Write, o_AV_WriteData,
      input  i_AV_ReadData, i_AV_WaitRequest,
      input  i_Req_Valid, i_Req_Data, i_Req_Last,
      output o_Req_Ready, o_Grant, o_CfgDone
   );

   modport slave (
      input  o_AV_Address, o_AV_ByteEn, o_AV_Read, o_AV_Write, o_AV_WriteData,
      output i_AV_ReadData, i_AV_WaitRequest,
      output i_Req_Valid, i_Req_Data, i_Req_Last,
      input  o_Req_Ready, o_Grant, o_CfgDone
   );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin search: first active request strictly after the last owner, wrapping.
// Purely combinational; the caller registers the result.
module rr_arbiter #(
   parameter int P_NUM_REQ = 4,
   parameter int IDX_W     = $clog2(P_NUM_REQ)
) (
   input  logic [P_NUM_REQ-1:0] reqVec,
   input  logic [IDX_W-1:0]     lastOwner,
   output logic [P_NUM_REQ-1:0] grantVec,
   output logic [IDX_W-1:0]     grantIdx,
   output logic                 anyReq
);

   always_comb begin
      int cand;
      logic [P_NUM_REQ-1:0] shifted;
      grantVec = '0;
      grantIdx = '0;
      anyReq   = 1'b0;
      cand     = 0;
      shifted  = '0;
      for (int i = 1; i <= P_NUM_REQ; i++) begin
         cand    = (int'(lastOwner) + i) % P_NUM_REQ;
         shifted = reqVec >> cand;
         if (!anyReq && shifted[0]) begin
            anyReq   = 1'b1;
            grantVec = P_NUM_REQ'(1) << cand;
            grantIdx = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Configures a UART over Avalon after reset, then feeds it bytes from several
// requesters with round-robin arbitration locked for the duration of a packet.
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int          P_NUM_REQ      = 4,
   parameter int          P_BASE_ADDR    = 0,
   parameter int          P_ADDR_W       = 30,
   parameter logic [15:0] P_CLKS_PER_BIT = 16'd868,
   parameter logic        P_RX_EN        = 1'b1,
   parameter logic        P_FC_EN        = 1'b0
) (
   input logic                 i_Clk,
   input logic                 i_nRst,
   uart_tx_scheduler_if.master bus
);

   localparam int                  IDX_W     = $clog2(P_NUM_REQ);
   localparam logic [P_ADDR_W-1:0] CTRL_ADDR = P_ADDR_W'(P_BASE_ADDR + REG_CTRL);
   localparam logic [P_ADDR_W-1:0] DATA_ADDR = P_ADDR_W'(P_BASE_ADDR + REG_DATA);
   localparam logic [31:0]         CFG_WORD  = cfgWord(P_CLKS_PER_BIT, P_RX_EN, P_FC_EN);

   schedState_t          state;
   logic [IDX_W-1:0]     lastOwner;
   logic [IDX_W-1:0]     ownerIdx;
   logic [P_NUM_REQ-1:0] arbGrant;
   logic [IDX_W-1:0]     arbIdx;
   logic                 anyReq;
   logic [7:0]           ownerByte;
   logic                 ownerValid;
   logic                 ownerLast;
   logic                 unusedStatus;

   rr_arbiter #(.P_NUM_REQ(P_NUM_REQ), .IDX_W(IDX_W)) arbiter (
      .reqVec    (bus.i_Req_Valid),
      .lastOwner (lastOwner),
      .grantVec  (arbGrant),
      .grantIdx  (arbIdx),
      .anyReq    (anyReq)
   );

   // The one-hot grant doubles as the mux select for the owner's byte stream.
   always_comb begin
      ownerByte = '0;
      for (int k = 0; k < P_NUM_REQ; k++) begin
         if (bus.o_Grant[k]) ownerByte = bus.i_Req_Data[8*k +: 8];
      end
   end

   assign ownerValid      = |(bus.o_Grant & bus.i_Req_Valid);
   assign ownerLast       = |(bus.o_Grant & bus.i_Req_Last);
   assign bus.o_Req_Ready = (state == WRITE && !bus.i_AV_WaitRequest) ? bus.o_Grant : '0;
   assign unusedStatus    = ^{bus.i_AV_ReadData[31:TX_FULL+1], bus.i_AV_ReadData[TX_FULL-1:0]};

   // Strobes are raised on the transition into a state, so each state's
   // transfer is already on the bus during its first cycle.
   always_ff @(posedge i_Clk) begin
      if (!i_nRst) begin
         state              <= CFG;
         lastOwner          <= '0;
         ownerIdx           <= '0;
         bus.o_AV_Address   <= '0;
         bus.o_AV_ByteEn    <= '0;
         bus.o_AV_Read      <= 1'b0;
         bus.o_AV_Write     <= 1'b0;
         bus.o_AV_WriteData <= '0;
         bus.o_Grant        <= '0;
         bus.o_CfgDone      <= 1'b0;
      end else begin
         case (state)
            CFG: begin
               if (!bus.o_AV_Write) begin
                  bus.o_AV_Write     <= 1'b1;
                  bus.o_AV_Address   <= CTRL_ADDR;
                  bus.o_AV_ByteEn    <= BE_CFG;
                  bus.o_AV_WriteData <= CFG_WORD;
               end else if (!bus.i_AV_WaitRequest) begin
                  bus.o_AV_Write <= 1'b0;
                  bus.o_CfgDone  <= 1'b1;
                  state          <= ARB;
               end
            end
            ARB: begin
               if ((bus.o_Grant == '0 && anyReq) || (bus.o_Grant != '0 && ownerValid)) begin
                  if (bus.o_Grant == '0) begin
                     bus.o_Grant <= arbGrant;
                     ownerIdx    <= arbIdx;
                  end
                  bus.o_AV_Read    <= 1'b1;
                  bus.o_AV_Address <= CTRL_ADDR;
                  bus.o_AV_ByteEn  <= BE_POLL;
                  state            <= POLL;
               end
            end
            POLL: begin
               if (!bus.i_AV_WaitRequest) begin
                  bus.o_AV_Read <= 1'b0;
                  state         <= PWAIT;
               end
            end
            PWAIT: begin
               if (bus.i_AV_ReadData[TX_FULL]) begin
                  bus.o_AV_Read <= 1'b1;
                  state         <= POLL;
               end else begin
                  bus.o_AV_Write     <= 1'b1;
                  bus.o_AV_Address   <= DATA_ADDR;
                  bus.o_AV_ByteEn    <= BE_DATA;
                  bus.o_AV_WriteData <= {24'h0, ownerByte};
                  state              <= WRITE;
               end
            end
            WRITE: begin
               if (!bus.i_AV_WaitRequest) begin
                  bus.o_AV_Write <= 1'b0;
                  state          <= ARB;
                  if (ownerLast) begin
                     bus.o_Grant <= '0;
                     lastOwner   <= ownerIdx;
                  end
               end
            end
            default: state <= CFG;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed and randomized checks of the UART transmit scheduler against a
// packet-level round-robin model and a simple UART slave responder.
module tb_uart_tx_scheduler;

   localparam int             NUM       = 4;
   localparam int             AW        = 30;
   localparam int             BASE      = 'h100;
   localparam logic [AW-1:0]  CTRL_ADDR = AW'(BASE);
   localparam logic [AW-1:0]  DATA_ADDR = AW'(BASE + 1);
   localparam logic [31:0]    CFG_EXP   = 32'h0003_0364;

   logic clk  = 1'b0;
   logic nRst = 1'b0;
   always #5 clk = ~clk;

   uart_tx_scheduler_if #(.P_NUM_REQ(NUM), .P_ADDR_W(AW)) bus ();

   uart_tx_scheduler #(
      .P_NUM_REQ(NUM), .P_BASE_ADDR(BASE), .P_ADDR_W(AW),
      .P_CLKS_PER_BIT(16'd868), .P_RX_EN(1'b1), .P_FC_EN(1'b0)
   ) dut (
      .i_Clk (clk),
      .i_nRst(nRst),
      .bus   (bus)
   );

   int             errors = 0;
   int             checks = 0;
   logic [8:0]     reqQ [NUM][$];
   logic [NUM-1:0] reqEn;
   int             expReq[$];
   logic [7:0]     expByte[$];
   int             modelPtr = 0;
   int             stallLeft = 0, fullCount = 0, randWaitPct = 0, randFullPct = 0;
   bit             readPending = 0, stalled = 0;
   logic [AW-1:0]  holdAddr;
   logic [3:0]     holdBe;
   logic [31:0]    holdWd;
   logic [1:0]     holdStrobes;
   int             cycleCount = 0, pollCount = 0, cfgWrites = 0, phaseStart = 0;
   int             writeCycles[$];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Each requester presents the head of its queue; Data/Last hold until consumed.
   task automatic applyStimulus();
      for (int k = 0; k < NUM; k++) begin
         if (reqEn[k] && reqQ[k].size() > 0) begin
            bus.i_Req_Valid[k]      = 1'b1;
            bus.i_Req_Data[8*k +: 8] = reqQ[k][0][7:0];
            bus.i_Req_Last[k]       = reqQ[k][0][8];
         end else begin
            bus.i_Req_Valid[k]      = 1'b0;
            bus.i_Req_Data[8*k +: 8] = 8'h00;
            bus.i_Req_Last[k]       = 1'b0;
         end
      end
   endtask

   task automatic addByte(input int k, input logic [7:0] b, input logic last);
      reqQ[k].push_back({last, b});
   endtask

   // Whole packets are granted round-robin, starting after the previous owner.
   task automatic buildExpected();
      logic [8:0] copyQ [NUM][$];
      logic [8:0] item;
      int owner;
      bit found;
      for (int k = 0; k < NUM; k++) copyQ[k] = reqQ[k];
      owner = modelPtr;
      found = 1;
      while (found) begin
         found = 0;
         for (int i = 1; i <= NUM && !found; i++) begin
            int c;
            c = (owner + i) % NUM;
            if (copyQ[c].size() > 0) begin
               found = 1;
               owner = c;
               do begin
                  item = copyQ[c].pop_front();
                  expReq.push_back(c);
                  expByte.push_back(item[7:0]);
               end while (!item[8] && copyQ[c].size() > 0);
            end
         end
      end
      modelPtr = owner;
   endtask

   // One clock cycle: answer as the UART slave, check the bus, then advance.
   task automatic cycle();
      logic [31:0] status;
      logic [7:0]  b;
      logic        wrAcc, rdAcc;
      int          r;
      int          consumed;
      consumed = -1;
      if (readPending) begin
         status = $urandom;
         if (fullCount > 0) begin
            status[19] = 1'b1;
            fullCount--;
         end else begin
            status[19] = (randFullPct > 0 && $urandom_range(0, 99) < randFullPct);
         end
         bus.i_AV_ReadData = status;
      end else begin
         bus.i_AV_ReadData = $urandom;
      end
      if (bus.o_AV_Write && bus.o_AV_Address == DATA_ADDR && stallLeft > 0) begin
         bus.i_AV_WaitRequest = 1'b1;
         stallLeft--;
      end else begin
         bus.i_AV_WaitRequest = (randWaitPct > 0 && $urandom_range(0, 99) < randWaitPct);
      end
      #1;
      checkOutput("rd_wr_exclusive", 32'(bus.o_AV_Read & bus.o_AV_Write), 32'h0);
      if (stalled) begin
         checkOutput("stall_addr", 32'(bus.o_AV_Address), 32'(holdAddr));
         checkOutput("stall_byteen", 32'(bus.o_AV_ByteEn), 32'(holdBe));
         checkOutput("stall_wdata", bus.o_AV_WriteData, holdWd);
         checkOutput("stall_strobes", 32'({bus.o_AV_Read, bus.o_AV_Write}), 32'(holdStrobes));
      end
      wrAcc = bus.o_AV_Write && !bus.i_AV_WaitRequest;
      rdAcc = bus.o_AV_Read && !bus.i_AV_WaitRequest;
      if (wrAcc && bus.o_AV_Address == DATA_ADDR) begin
         if (expReq.size() == 0) begin
            checkOutput("data_write_expected", 32'(expReq.size()), 32'h1);
         end else begin
            r = expReq.pop_front();
            b = expByte.pop_front();
            checkOutput("data_wdata", bus.o_AV_WriteData, {24'h0, b});
            checkOutput("data_byteen", 32'(bus.o_AV_ByteEn), 32'h1);
            checkOutput("data_ready", 32'(bus.o_Req_Ready), 1 << r);
            checkOutput("data_grant", 32'(bus.o_Grant), 1 << r);
            consumed = r;
            writeCycles.push_back(cycleCount);
         end
      end else begin
         checkOutput("ready_idle", 32'(bus.o_Req_Ready), 32'h0);
         if (wrAcc && bus.o_AV_Address == CTRL_ADDR) begin
            cfgWrites++;
            checkOutput("cfg_wdata", bus.o_AV_WriteData, CFG_EXP);
            checkOutput("cfg_byteen", 32'(bus.o_AV_ByteEn), 32'h7);
         end else if (wrAcc) begin
            checkOutput("write_addr", 32'(bus.o_AV_Address), 32'(DATA_ADDR));
         end
      end
      if (rdAcc) begin
         pollCount++;
         checkOutput("poll_addr", 32'(bus.o_AV_Address), 32'(CTRL_ADDR));
         checkOutput("poll_byteen", 32'(bus.o_AV_ByteEn), 32'hF);
      end
      readPending = rdAcc;
      stalled     = (bus.o_AV_Read || bus.o_AV_Write) && bus.i_AV_WaitRequest;
      holdAddr    = bus.o_AV_Address;
      holdBe      = bus.o_AV_ByteEn;
      holdWd      = bus.o_AV_WriteData;
      holdStrobes = {bus.o_AV_Read, bus.o_AV_Write};
      @(posedge clk);
      #1;
      cycleCount++;
      if (consumed >= 0 && reqQ[consumed].size() > 0) void'(reqQ[consumed].pop_front());
      applyStimulus();
   endtask

   task automatic startPhase();
      applyStimulus();
      buildExpected();
      writeCycles.delete();
      pollCount  = 0;
      phaseStart = cycleCount;
   endtask

   task automatic runUntilDrained(input string tag, input int budget);
      int n;
      int left;
      n = 0;
      while (expReq.size() > 0 && n < budget) begin
         cycle();
         n++;
      end
      checkOutput({tag, "_drained"}, 32'(expReq.size()), 32'h0);
      cycle();
      checkOutput({tag, "_grant_released"}, 32'(bus.o_Grant), 32'h0);
      left = 0;
      for (int k = 0; k < NUM; k++) left += reqQ[k].size();
      checkOutput({tag, "_queues_empty"}, 32'(left), 32'h0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_addr"}, 32'(bus.o_AV_Address), 32'h0);
      checkOutput({tag, "_byteen"}, 32'(bus.o_AV_ByteEn), 32'h0);
      checkOutput({tag, "_read"}, 32'(bus.o_AV_Read), 32'h0);
      checkOutput({tag, "_write"}, 32'(bus.o_AV_Write), 32'h0);
      checkOutput({tag, "_wdata"}, bus.o_AV_WriteData, 32'h0);
      checkOutput({tag, "_ready"}, 32'(bus.o_Req_Ready), 32'h0);
      checkOutput({tag, "_grant"}, 32'(bus.o_Grant), 32'h0);
      checkOutput({tag, "_cfgdone"}, 32'(bus.o_CfgDone), 32'h0);
   endtask

   task automatic checkCfgIssued(input string tag);
      checkOutput({tag, "_cfg_write"}, 32'(bus.o_AV_Write), 32'h1);
      checkOutput({tag, "_cfg_addr"}, 32'(bus.o_AV_Address), 32'(CTRL_ADDR));
      checkOutput({tag, "_cfg_byteen"}, 32'(bus.o_AV_ByteEn), 32'h7);
      checkOutput({tag, "_cfg_wdata"}, bus.o_AV_WriteData, CFG_EXP);
      checkOutput({tag, "_cfg_grant"}, 32'(bus.o_Grant), 32'h0);
      checkOutput({tag, "_cfg_notdone"}, 32'(bus.o_CfgDone), 32'h0);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cycleCount);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      int gap;
      reqEn                = '1;
      bus.i_AV_WaitRequest = 1'b0;
      bus.i_AV_ReadData    = '0;
      bus.i_Req_Valid      = '0;
      bus.i_Req_Data       = '0;
      bus.i_Req_Last       = '0;

      // A: reset values, then the configuration write
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("A_reset");
      nRst = 1'b1;
      @(posedge clk);
      #1;
      checkCfgIssued("A");
      cfgWrites = 0;
      cycle();
      checkOutput("A_cfgdone", 32'(bus.o_CfgDone), 32'h1);
      checkOutput("A_write_dropped", 32'(bus.o_AV_Write), 32'h0);
      checkOutput("A_cfg_count", 32'(cfgWrites), 32'h1);

      // B: single requester, two-byte packet, zero wait states
      addByte(0, 8'h41, 1'b0);
      addByte(0, 8'h42, 1'b1);
      startPhase();
      runUntilDrained("B", 50);
      gap = (writeCycles.size() >= 2) ? writeCycles[1] - writeCycles[0] : -1;
      checkOutput("B_byte_spacing", 32'(gap), 32'h4);
      gap = (writeCycles.size() >= 1) ? writeCycles[0] - phaseStart : -1;
      checkOutput("B_first_latency", 32'(gap), 32'h3);

      // C: two contending requesters, packets must not interleave
      addByte(1, 8'h11, 1'b0);
      addByte(1, 8'h12, 1'b1);
      addByte(3, 8'h31, 1'b0);
      addByte(3, 8'h32, 1'b1);
      startPhase();
      runUntilDrained("C", 100);

      // D: TX FIFO reported full three times before space appears
      addByte(2, 8'hA5, 1'b1);
      fullCount = 3;
      startPhase();
      runUntilDrained("D", 100);
      checkOutput("D_poll_count", 32'(pollCount), 32'h4);
      gap = (writeCycles.size() >= 1) ? writeCycles[0] - phaseStart : -1;
      checkOutput("D_write_latency", 32'(gap), 32'h9);

      // E: slave stalls the data write for five cycles
      addByte(0, 8'h5C, 1'b1);
      stallLeft = 5;
      startPhase();
      runUntilDrained("E", 100);
      checkOutput("E_stalls_used", 32'(stallLeft), 32'h0);
      gap = (writeCycles.size() >= 1) ? writeCycles[0] - phaseStart : -1;
      checkOutput("E_write_latency", 32'(gap), 32'h8);

      // F: random packets on every requester with random stalls and full polls
      for (int k = 0; k < NUM; k++) begin
         int pkts;
         pkts = $urandom_range(1, 3);
         for (int p = 0; p < pkts; p++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) addByte(k, 8'($urandom), (j == len - 1));
         end
      end
      randWaitPct = 30;
      randFullPct = 25;
      startPhase();
      runUntilDrained("F", 4000);
      randWaitPct = 0;
      randFullPct = 0;
      bus.i_AV_WaitRequest = 1'b0;

      // G: reset pulse while polling abandons the byte and reconfigures
      addByte(1, 8'h77, 1'b1);
      startPhase();
      n = 0;
      while (!bus.o_AV_Read && n < 20) begin
         cycle();
         n++;
      end
      checkOutput("G_reached_poll", 32'(bus.o_AV_Read), 32'h1);
      nRst = 1'b0;
      bus.i_AV_WaitRequest = 1'b0;
      @(posedge clk);
      #1;
      checkAllZero("G_reset");
      nRst        = 1'b1;
      readPending = 0;
      stalled     = 0;
      expReq.delete();
      expByte.delete();
      modelPtr = 0;
      buildExpected();
      @(posedge clk);
      #1;
      checkCfgIssued("G");
      cfgWrites = 0;
      runUntilDrained("G", 100);
      checkOutput("G_cfg_reissued", 32'(cfgWrites), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
